// File: rtl/enc_pkg.sv
// Shared widths and FSM state encoding for the serial 8-to-3 encoder.
package enc_pkg;
  localparam int IN_W   = 8;
  localparam int CODE_W = 3;

  typedef enum logic {
    IDLE,
    EMIT
  } enc_state_t;
endpackage

// File: rtl/pri_enc8.sv
// Combinational 8-input priority encoder: selected index, any-set flag and
// at-most-one-set flag.
module pri_enc8
  import enc_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b0
) (
  input  logic [IN_W-1:0]   i_vec,
  output logic [CODE_W-1:0] o_idx,
  output logic              o_any,
  output logic              o_one_or_less
);

  // Later loop iterations overwrite earlier ones, so scan order picks the winner.
  always_comb begin
    o_idx = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < IN_W; i++)
        if (i_vec[i]) o_idx = CODE_W'(i);
    end else begin
      for (int i = IN_W - 1; i >= 0; i--)
        if (i_vec[i]) o_idx = CODE_W'(i);
    end
  end

  assign o_any         = |i_vec;
  assign o_one_or_less = ((i_vec & (i_vec - IN_W'(1))) == '0);

endmodule

// File: rtl/encoder8to3_serial.sv
// Serial 8-to-3 encoder: accepts a request word, then emits one 3-bit code per
// set bit in priority order (a zero word yields one "none" beat).
module encoder8to3_serial
  import enc_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IN_W-1:0]   in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              out_none
);

  enc_state_t        r_state;
  logic [IN_W-1:0]   r_pend;
  logic              r_none;

  logic [CODE_W-1:0] w_idx;
  logic              w_any;
  logic              w_one;
  logic              w_beat;
  logic              w_accept;

  pri_enc8 #(
    .PRIORITY_HIGH(PRIORITY_HIGH)
  ) u_pri (
    .i_vec        (r_pend),
    .o_idx        (w_idx),
    .o_any        (w_any),
    .o_one_or_less(w_one)
  );

  // Beat fields are gated by out_valid so IDLE shows all zeros.
  assign out_valid = (r_state == EMIT);
  assign out_code  = (out_valid && w_any) ? w_idx : '0;
  assign out_last  = out_valid && w_one;
  assign out_none  = out_valid && r_none;

  assign w_beat   = out_valid && out_ready;
  assign in_ready = (r_state == IDLE) || (w_beat && out_last);
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pend  <= '0;
      r_none  <= 1'b0;
    end else if (w_accept) begin
      // Also covers chaining on the last beat: reload and stay in EMIT.
      r_state <= EMIT;
      r_pend  <= in;
      r_none  <= (in == '0);
    end else if (w_beat) begin
      r_pend <= r_pend & ~(IN_W'(1) << out_code);
      if (out_last) begin
        r_state <= IDLE;
        r_none  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_encoder8to3_serial.sv
// Bench for encoder8to3_serial: one instance per priority order, expected
// beats queued at stimulus time and popped as the DUT hands them over.
module tb_encoder8to3_serial;

  logic       clk;
  logic       rst_n;

  logic       lo_in_valid, lo_in_ready, lo_out_valid, lo_out_ready;
  logic       lo_out_last, lo_out_none;
  logic [7:0] lo_in;
  logic [2:0] lo_out_code;

  logic       hi_in_valid, hi_in_ready, hi_out_valid, hi_out_ready;
  logic       hi_out_last, hi_out_none;
  logic [7:0] hi_in;
  logic [2:0] hi_out_code;

  logic [4:0] lo_q[$];
  logic [4:0] hi_q[$];
  logic [4:0] exp_b;
  logic       lo_acc, hi_acc;
  int         checks = 0;
  int         errors = 0;
  int         n_cyc;

  encoder8to3_serial #(.PRIORITY_HIGH(1'b0)) u_lo (
    .clk(clk), .rst_n(rst_n),
    .in_valid(lo_in_valid), .in_ready(lo_in_ready), .in(lo_in),
    .out_valid(lo_out_valid), .out_ready(lo_out_ready),
    .out_code(lo_out_code), .out_last(lo_out_last), .out_none(lo_out_none)
  );

  encoder8to3_serial #(.PRIORITY_HIGH(1'b1)) u_hi (
    .clk(clk), .rst_n(rst_n),
    .in_valid(hi_in_valid), .in_ready(hi_in_ready), .in(hi_in),
    .out_valid(hi_out_valid), .out_ready(hi_out_ready),
    .out_code(hi_out_code), .out_last(hi_out_last), .out_none(hi_out_none)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference beats {code,last,none} for one word.
  task automatic push_exp(input bit hi, input logic [7:0] w);
    int n;
    int k;
    int idx;
    logic [4:0] b;
    n = $countones(w);
    k = 0;
    if (w == 8'h00) begin
      b = {3'd0, 1'b1, 1'b1};
      if (hi) hi_q.push_back(b); else lo_q.push_back(b);
    end else begin
      for (int j = 0; j < 8; j++) begin
        idx = hi ? 7 - j : j;
        if (w[idx]) begin
          k++;
          b = {3'(idx), (k == n), 1'b0};
          if (hi) hi_q.push_back(b); else lo_q.push_back(b);
        end
      end
    end
  endtask

  // One clock: check handshakes on the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    lo_acc = lo_in_ready;
    hi_acc = hi_in_ready;
    if (lo_in_valid) begin
      checks++;
      assert (!$isunknown(lo_in)) else begin errors++; $error("FAIL lo_in_x in=%b required=known", lo_in); end
    end
    if (hi_in_valid) begin
      checks++;
      assert (!$isunknown(hi_in)) else begin errors++; $error("FAIL hi_in_x in=%b required=known", hi_in); end
    end
    if (rst_n && lo_out_valid && lo_out_ready) begin
      checks++;
      if (lo_q.size() == 0) begin
        errors++;
        $error("FAIL lo_extra_beat got=%b required=no beat", {lo_out_code, lo_out_last, lo_out_none});
      end else begin
        exp_b = lo_q.pop_front();
        assert ({lo_out_code, lo_out_last, lo_out_none} === exp_b) else begin
          errors++;
          $error("FAIL lo_beat got=%b required=%b", {lo_out_code, lo_out_last, lo_out_none}, exp_b);
        end
      end
    end
    if (rst_n && hi_out_valid && hi_out_ready) begin
      checks++;
      if (hi_q.size() == 0) begin
        errors++;
        $error("FAIL hi_extra_beat got=%b required=no beat", {hi_out_code, hi_out_last, hi_out_none});
      end else begin
        exp_b = hi_q.pop_front();
        assert ({hi_out_code, hi_out_last, hi_out_none} === exp_b) else begin
          errors++;
          $error("FAIL hi_beat got=%b required=%b", {hi_out_code, hi_out_last, hi_out_none}, exp_b);
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit hi, input logic [7:0] w);
    bit ok;
    ok = 1'b0;
    push_exp(hi, w);
    if (hi) begin hi_in_valid = 1'b1; hi_in = w; end
    else    begin lo_in_valid = 1'b1; lo_in = w; end
    for (int i = 0; i < 20 && !ok; i++) begin
      tick();
      ok = hi ? hi_acc : lo_acc;
    end
    if (hi) begin hi_in_valid = 1'b0; hi_in = 8'h00; end
    else    begin lo_in_valid = 1'b0; lo_in = 8'h00; end
    checks++;
    assert (ok) else begin errors++; $error("FAIL accept_%0h got=not accepted required=accepted", w); end
  endtask

  task automatic drain(input bit hi, input int exp_cyc, input string tag);
    int c;
    c = 0;
    while (c < 50 && (hi ? (hi_out_valid || hi_q.size() != 0)
                         : (lo_out_valid || lo_q.size() != 0))) begin
      tick();
      c++;
    end
    checks++;
    assert (c === exp_cyc) else begin
      errors++;
      $error("FAIL %s cycles got=%0d required=%0d", tag, c, exp_cyc);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    lo_in_valid = 1'b0; lo_in = 8'h00; lo_out_ready = 1'b1;
    hi_in_valid = 1'b0; hi_in = 8'h00; hi_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    assert ({lo_out_valid, lo_in_ready, lo_out_code, lo_out_last, lo_out_none} === 7'b0100000)
      else begin errors++; $error("FAIL lo_in_reset got=%b required=0100000",
        {lo_out_valid, lo_in_ready, lo_out_code, lo_out_last, lo_out_none}); end
    rst_n = 1'b1;
    repeat (3) tick();
    checks++;
    assert ({lo_out_valid, lo_in_ready, lo_out_code, lo_out_last, lo_out_none} === 7'b0100000)
      else begin errors++; $error("FAIL lo_after_reset got=%b required=0100000",
        {lo_out_valid, lo_in_ready, lo_out_code, lo_out_last, lo_out_none}); end
    checks++;
    assert ({hi_out_valid, hi_in_ready, hi_out_code, hi_out_last, hi_out_none} === 7'b0100000)
      else begin errors++; $error("FAIL hi_after_reset got=%b required=0100000",
        {hi_out_valid, hi_in_ready, hi_out_code, hi_out_last, hi_out_none}); end

    // Low-first order: 2, 5, 7 on consecutive cycles.
    send(1'b0, 8'b1010_0100);
    drain(1'b0, 3, "lo_a4");
    send(1'b0, 8'h00);
    drain(1'b0, 1, "lo_zero");

    // High-first order.
    send(1'b1, 8'hFF);
    drain(1'b1, 8, "hi_ff");
    send(1'b1, 8'b1010_0100);
    drain(1'b1, 3, "hi_a4");
    send(1'b1, 8'h00);
    drain(1'b1, 1, "hi_zero");

    // Stall the first beat three cycles, then chain 8'h80 onto the last beat.
    lo_out_ready = 1'b0;
    send(1'b0, 8'b0001_0010);
    for (int i = 0; i < 3; i++) begin
      checks++;
      assert ({lo_out_valid, lo_out_code, lo_out_last, lo_out_none} === 6'b1_001_0_0)
        else begin errors++; $error("FAIL lo_stall%0d got=%b required=100100", i,
          {lo_out_valid, lo_out_code, lo_out_last, lo_out_none}); end
      tick();
    end
    lo_out_ready = 1'b1;
    checks++;
    assert ({lo_out_valid, lo_out_code} === 4'b1_001)
      else begin errors++; $error("FAIL lo_stall_release got=%b required=1001", {lo_out_valid, lo_out_code}); end
    tick();
    checks++;
    assert ({lo_out_valid, lo_out_code, lo_out_last} === 5'b1_100_1)
      else begin errors++; $error("FAIL lo_last4 got=%b required=11001", {lo_out_valid, lo_out_code, lo_out_last}); end
    send(1'b0, 8'h80);
    checks++;
    assert ({lo_out_valid, lo_out_code} === 4'b1_111)
      else begin errors++; $error("FAIL lo_chain_nogap got=%b required=1111", {lo_out_valid, lo_out_code}); end
    drain(1'b0, 1, "lo_chain");

    // Reset in the middle of 8'h0E after code 1 has gone out.
    send(1'b0, 8'h0E);
    tick();
    rst_n = 1'b0;
    #1;
    checks++;
    assert ({lo_out_valid, lo_in_ready} === 2'b01)
      else begin errors++; $error("FAIL lo_async_reset got=%b required=01", {lo_out_valid, lo_in_ready}); end
    lo_q.delete();
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      assert (lo_out_valid === 1'b0)
        else begin errors++; $error("FAIL lo_no_resume%0d got=%b required=0", i, lo_out_valid); end
    end
    send(1'b0, 8'h01);
    drain(1'b0, 1, "lo_after_mid_reset");

    checks++;
    assert (lo_q.size() == 0 && hi_q.size() == 0)
      else begin errors++; $error("FAIL queues_empty got=%0d/%0d required=0/0", lo_q.size(), hi_q.size()); end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/encoder8to3_serial.md
# encoder8to3_serial

Sequential 8-to-3 encoder: the inverse of the team's 3-to-8 decoder. It accepts an 8-bit request or flag word over a valid/ready handshake and emits one 3-bit binary code per set bit, in priority order, on a second valid/ready stream. It sits between status/request vectors, such as decoder outputs or interrupt flags, and logic that consumes one index at a time.

## Interface
- `PRIORITY_HIGH`, default 0, sets emission order: 0 = lowest set index first, 1 = highest set index first.
- `clk` input 1: the single clock. All state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: the upstream word on `in` is valid.
- `in_ready` output 1: the block can accept a word this cycle.
- `in` input 8: request word; bit i set means code i is to be emitted.
- `out_valid` output 1: `out_code`, `out_last` and `out_none` are valid.
- `out_ready` input 1: downstream accepts the current beat.
- `out_code` output 3: binary index of the current set bit.
- `out_last` output 1: the current beat is the final beat for this word.
- `out_none` output 1: the accepted word was 8'h00.

## Operation
- **State registers:** state (`IDLE`/`EMIT`), 8-bit pending mask `pend`, and a `none` flag.
- **Reset (rst_n low, asynchronous):**
  - state = `IDLE`, `pend` = 0, `none` = 0.
  - Outputs: `out_valid` = 0, `out_code` = 0, `out_last` = 0, `out_none` = 0, `in_ready` = 1.
- **IDLE:**
  - `in_ready` = 1, `out_valid` = 0.
  - On `in_valid` && `in_ready`: `pend` <= `in`, `none` <= (`in` == 0), go to `EMIT`.
- **EMIT:**
  - `out_valid` = 1.
  - `out_code` = lowest set index of `pend` (`PRIORITY_HIGH` = 0) or highest set index (`PRIORITY_HIGH` = 1).
  - `out_last` = (`pend` has at most one bit set).
  - `out_none` = `none`.
  - If `pend` == 0 (none case): `out_code` = 0, `out_last` = 1, `out_none` = 1.
  - On `out_valid` && `out_ready` && !`out_last`: clear the emitted bit in `pend`, stay in `EMIT`.
  - On `out_valid` && `out_ready` && `out_last`: go to `IDLE`, unless a new word is accepted in the same cycle (see below).
- **Back-to-back words:** `in_ready` = (state == `IDLE`) || (`out_valid` && `out_ready` && `out_last`).
  - If a word is accepted in the last-beat cycle, load `pend`/`none` and remain in `EMIT`.
- **Beat count:** a word with k set bits produces exactly k beats. A zero word produces exactly 1 beat (`out_none` = 1). The maximum is 8 beats.
- **Output derivation:** `out_code`, `out_last` and `out_none` come combinationally from registered state only. `in_ready` is the only output with a combinational input path (from `out_ready`).
- **Backpressure:** while `out_valid` && !`out_ready`, all out_* signals hold stable and `pend` is unchanged.
- **Ignored input:** `in` is ignored unless `in_valid` && `in_ready`.

## Timing
- **Latency:** a word accepted at edge N has its first beat valid after edge N (same cycle as state = `EMIT`).
- **Throughput:**
  - One beat per cycle when `out_ready` is held high.
  - A new word costs 0 idle cycles if it is presented during the last beat, otherwise 1 cycle in `IDLE`.
- **Reset mid-word:** pending bits are discarded, `out_valid` drops immediately (asynchronously), and no partial word resumes after release.
- **Illegal input:** X on `in` while `in_valid` = 1 is illegal. It is not checked in RTL and is flagged by a bench assertion.

## Structure
- **Package `enc_pkg`:**
  - `localparam IN_W = 8`, `CODE_W = 3`.
  - State typedef `enc_state_t` {`IDLE`, `EMIT`}.
- **Sub-module `pri_enc8`:** combinational.
  - Input: 8-bit vector, parameter `PRIORITY_HIGH`.
  - Outputs: 3-bit index, `any`, `one_or_less`.
  - The top level uses it for `out_code`/`out_last`, and clears the emitted bit with `pend & ~(8'b1 << out_code)`.

## Test plan
1. Reset: hold `rst_n` low, then release -> `out_valid` = 0 and `in_ready` = 1; no beats emitted while `in_valid` = 0.
2. `PRIORITY_HIGH` = 0, `in` = 8'b1010_0100, `out_ready` = 1 -> beats with codes 2, 5, 7 on consecutive cycles; `out_last` only on 7; `out_none` = 0 throughout.
3. `in` = 8'h00 -> single beat with `out_code` = 0, `out_last` = 1, `out_none` = 1; then back to `IDLE`.
4. `PRIORITY_HIGH` = 1, `in` = 8'hFF -> codes 7, 6, 5, 4, 3, 2, 1, 0; `out_last` on 0; 8 beats total.
5. Backpressure and chaining:
   - `in` = 8'b0001_0010 with `out_ready` low for 3 cycles on the first beat -> code 1 held stable for 4 cycles, then code 4 with `out_last`.
   - Present `in` = 8'h80 during that last beat -> it is accepted in the same cycle, and code 7 follows on the next cycle with no gap.
6. Reset mid-word: `in` = 8'h0E, pulse `rst_n` low after the first beat (code 1) -> `out_valid` = 0 immediately; next word 8'h01 yields exactly one beat, code 0.
